// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// select codes, condition codes and the condition evaluator.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // flags are packed {N,Z,C,V}; code 1111 never executes
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_cond_logic.sv
// NZCV flag register, condition evaluation latched at DECODE, and gating of
// every architectural write strobe by the latched condition.
module mc_controller_cond_logic
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       capture,
  input  logic [1:0] flag_w,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       next_pc,
  input  logic       branch,
  input  logic       rd_is_pc,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags
);

  logic cond_ex_q;
  logic pcs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags     <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      if (capture) cond_ex_q <= cond_true(cond, flags);
      if (flag_w[1] && cond_ex_q) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && cond_ex_q) flags[1:0] <= alu_flags[1:0];
    end
  end

  // a register write to R15 is redirected into a PC write
  assign pcs       = (rd_is_pc & reg_w) | branch;
  assign pc_write  = next_pc | (pcs & cond_ex_q);
  assign reg_write = reg_w & cond_ex_q & ~rd_is_pc;
  assign mem_write = mem_w & cond_ex_q;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM with Moore strobes, ALU/immediate
// decode, and the condition/flag unit.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [3:0]  dbg_state,
  output logic [3:0]  dbg_flags
);

  state_t     state, state_n;
  logic [3:0] cond, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       next_pc, reg_w, mem_w, branch, alu_op;
  logic       alu_known, alu_add_sub;
  logic [1:0] flag_w;
  logic       unused_rn;

  // Instr carries IR[31:12]
  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALURESULT; next_pc = 1'b1;
        state_n = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
        case (op)
          OP_MEM:  state_n = S_MEMADR;
          OP_DP:   state_n = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_n = S_BRANCH;
          default: state_n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_n = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1; state_n = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA; reg_w = 1'b1; state_n = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; mem_w = 1'b1; state_n = S_FETCH;
      end
      S_EXECR: begin
        alu_op = 1'b1; state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = SRCB_IMM; alu_op = 1'b1; state_n = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1; state_n = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; branch = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // unrecognised DP commands fall back to ADD and never touch the flags
  always_comb begin
    ALUControl  = ALU_ADD;
    alu_known   = 1'b0;
    alu_add_sub = 1'b0;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: begin ALUControl = ALU_ADD; alu_known = 1'b1; alu_add_sub = 1'b1; end
        4'b0010: begin ALUControl = ALU_SUB; alu_known = 1'b1; alu_add_sub = 1'b1; end
        4'b0000: begin ALUControl = ALU_AND; alu_known = 1'b1; end
        4'b1100: begin ALUControl = ALU_ORR; alu_known = 1'b1; end
        default: ALUControl = ALU_ADD;
      endcase
    end
  end

  assign flag_w[1] = alu_op & funct[0] & alu_known;
  assign flag_w[0] = alu_op & funct[0] & alu_add_sub;

  always_comb begin
    case (op)
      OP_MEM:  ImmSrc = IMM_MEM;
      OP_BR:   ImmSrc = IMM_BR;
      default: ImmSrc = IMM_DP;
    endcase
  end

  assign RegSrc = {op == OP_MEM, op == OP_BR};

  mc_controller_cond_logic u_cond (
    .clk       (clk),
    .rst       (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .capture   (state == S_DECODE),
    .flag_w    (flag_w),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .next_pc   (next_pc),
    .branch    (branch),
    .rd_is_pc  (rd == 4'd15),
    .pc_write  (PCWrite),
    .reg_write (RegWrite),
    .mem_write (MemWrite),
    .flags     (dbg_flags)
  );

endmodule
